// File: rtl/aes_xts_sector_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : aes_xts_sector_sequencer
// Purpose  : Steps one XTS sector through key load, tweak and per-block writes
//            to the AES-XTS block controller, flagging ciphertext stealing.
// Revision : 1.0 - initial release
// ============================================================================
module aes_xts_sector_sequencer #(
    parameter int LEN_W = 16
) (
    input  logic             inClk,
    input  logic             inResetN,
    input  logic             inStart,
    input  logic [LEN_W-1:0] inLength,
    input  logic             inAesMode,
    input  logic             inNewKey,
    input  logic             inAbort,
    input  logic             inDataValid,
    input  logic             inCoreBusy,
    input  logic             inCoreKeysReady,
    output logic             outDataReady,
    output logic             outCoreAesMode,
    output logic             outCoreKeyWr,
    output logic             outCoreTweakWr,
    output logic             outCoreDataWr,
    output logic             outCoreBlockNrWr,
    output logic [LEN_W-5:0] outCoreBlockNr,
    output logic             outCoreBlockBeforeLast,
    output logic             outCoreLastBlock,
    output logic             outBusy,
    output logic             outDone,
    output logic             outError
);

    localparam int IW = LEN_W - 4;
    localparam logic [IW:0] ONE = (IW+1)'(1);
    localparam logic [IW:0] TWO = (IW+1)'(2);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_KEY      = 3'd1,
        S_KEY_WAIT = 3'd2,
        S_TWEAK    = 3'd3,
        S_ISSUE    = 3'd4,
        S_GUARD    = 3'd5,
        S_WAIT     = 3'd6,
        S_DONE     = 3'd7
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW:0]   total_q, total_d;
    logic          steal_q, steal_d;
    logic          mode_q, mode_d;
    logic          err_q, err_d;

    logic          w_tail_nz;
    logic          w_short;
    logic [IW:0]   w_total;
    logic [IW:0]   w_idx_ext;
    logic          w_is_last;
    logic          w_is_bbl;
    logic          w_active;
    logic          w_issue;

    assign w_tail_nz = |inLength[3:0];
    assign w_short   = (inLength[LEN_W-1:4] == '0);
    assign w_total   = {1'b0, inLength[LEN_W-1:4]} + (IW+1)'(w_tail_nz);
    assign w_idx_ext = {1'b0, idx_q};
    assign w_is_last = (w_idx_ext == total_q - ONE);
    assign w_is_bbl  = (w_idx_ext == total_q - TWO);
    assign w_active  = (state_q == S_ISSUE) || (state_q == S_GUARD) || (state_q == S_WAIT);
    assign w_issue   = inDataValid & inCoreKeysReady & ~inCoreBusy;

    always_ff @(posedge inClk or negedge inResetN) begin
        if (!inResetN) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            total_q <= '0;
            steal_q <= 1'b0;
            mode_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            total_q <= total_d;
            steal_q <= steal_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        total_d          = total_q;
        steal_d          = steal_q;
        mode_d           = mode_q;
        err_d            = 1'b0;
        outDataReady     = 1'b0;
        outCoreKeyWr     = 1'b0;
        outCoreTweakWr   = 1'b0;
        outCoreDataWr    = 1'b0;
        outCoreBlockNrWr = 1'b0;
        outDone          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (inStart) begin
                    if (w_short) begin
                        err_d = 1'b1;
                    end else begin
                        total_d = w_total;
                        steal_d = w_tail_nz;
                        mode_d  = inAesMode;
                        idx_d   = '0;
                        state_d = inNewKey ? S_KEY : S_TWEAK;
                    end
                end
            end
            S_KEY: begin
                outCoreKeyWr = 1'b1;
                state_d      = S_KEY_WAIT;
            end
            S_KEY_WAIT: begin
                if (inCoreKeysReady) state_d = S_TWEAK;
            end
            S_TWEAK: begin
                outCoreTweakWr = 1'b1;
                idx_d          = '0;
                state_d        = S_ISSUE;
            end
            S_ISSUE: begin
                if (w_issue) begin
                    outDataReady     = 1'b1;
                    outCoreDataWr    = 1'b1;
                    outCoreBlockNrWr = 1'b1;
                    state_d          = S_GUARD;
                end
            end
            // Core busy may not have risen yet, so this cycle never samples it.
            S_GUARD: state_d = S_WAIT;
            S_WAIT: begin
                if (!inCoreBusy) begin
                    if (w_is_last) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                outDone = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything, including a same-cycle issue handshake.
        if (inAbort && (state_q != S_IDLE)) begin
            state_d          = S_IDLE;
            idx_d            = idx_q;
            outDataReady     = 1'b0;
            outCoreKeyWr     = 1'b0;
            outCoreTweakWr   = 1'b0;
            outCoreDataWr    = 1'b0;
            outCoreBlockNrWr = 1'b0;
            outDone          = 1'b0;
        end
    end

    assign outCoreAesMode         = mode_q;
    assign outCoreBlockNr         = idx_q;
    assign outCoreBlockBeforeLast = w_active & steal_q & w_is_bbl;
    assign outCoreLastBlock       = w_active & steal_q & w_is_last;
    assign outBusy                = (state_q != S_IDLE);
    assign outError               = err_q;

endmodule
`default_nettype wire
